edge_counter_quad: RTL and testbench

EDGE_COUNTER_QUAD -- requirements
Module: edge_counter_quad

---
 rtl/edge_counter_pkg.sv | 18 +
 rtl/edge_counter_channel.sv | 155 +++++++++++++++
 rtl/edge_counter_quad.sv | 75 +++++++
 tb/tb_edge_counter_quad.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_counter_pkg.sv
// Shared types and constants for the quad edge counter.
// Holds the per-channel state encoding, the default counter width and the
// saturation value of a default-width counter.
package edge_counter_pkg;

  localparam int unsigned N_CH          = 4;
  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } chan_state_e;

endpackage

// File: rtl/edge_counter_channel.sv
// One measurement channel: optional input synchronizer, inversion, edge
// detection, state machine, high/low/period counters and capture registers.
// Define EDGE_COUNTER_SYNC_EN to insert a 2-flop synchronizer on i_sig.
module edge_counter_channel
  import edge_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             i_sig,
  input  logic             i_trig,
  input  logic             i_enable,
  input  logic             i_trig_enable,
  input  logic             i_inv,
  output logic [CNT_W-1:0] o_d1,
  output logic [CNT_W-1:0] o_d2,
  output logic [CNT_W-1:0] o_d3,
  output logic             o_cap3
);

  localparam logic [CNT_W-1:0] L_MAX = '1;
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == L_MAX) ? v : v + L_ONE;
  endfunction

  logic             w_sig;
  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic             w_fall;
  chan_state_e      r_state;
  chan_state_e      w_next;
  logic             w_cap1;
  logic             w_cap23;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_low_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_d1;
  logic [CNT_W-1:0] r_d2;
  logic [CNT_W-1:0] r_d3;

`ifdef EDGE_COUNTER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for the asynchronous measured signal
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sig = r_sync2;
`else
  assign w_sig = i_sig;
`endif

  assign w_s    = w_sig ^ i_inv;
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  // Delayed copy of the conditioned input for edge detection
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) r_s_d <= 1'b0;
    else             r_s_d <= w_s;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  // Next-state and capture strobes; disable overrides every state
  always_comb begin
    w_next  = r_state;
    w_cap1  = 1'b0;
    w_cap23 = 1'b0;
    if (!i_enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      w_next = i_trig_enable ? ST_WAIT_TRIG : ST_ARM;
        ST_WAIT_TRIG: if (i_trig) w_next = ST_ARM;
        ST_ARM:       if (w_rise) w_next = ST_HIGH;
        ST_HIGH: begin
          if (w_fall) begin
            w_cap1 = 1'b1;
            w_next = ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_cap23 = 1'b1;
            w_next  = i_trig_enable ? ST_WAIT_TRIG : ST_HIGH;
          end
        end
        default:      w_next = ST_IDLE;
      endcase
    end
  end

  // Counters keyed on the state being entered: load 1 on entry, then
  // saturating increment; the period counter reloads on every rise.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
      r_per_cnt  <= '0;
    end else begin
      if (w_next == ST_HIGH)
        r_high_cnt <= (r_state == ST_HIGH) ? sat_inc(r_high_cnt) : L_ONE;
      else
        r_high_cnt <= '0;

      if (w_next == ST_LOW)
        r_low_cnt <= (r_state == ST_LOW) ? sat_inc(r_low_cnt) : L_ONE;
      else
        r_low_cnt <= '0;

      if (w_next == ST_HIGH || w_next == ST_LOW)
        r_per_cnt <= w_rise ? L_ONE : sat_inc(r_per_cnt);
      else
        r_per_cnt <= '0;
    end
  end

  // Capture registers hold their value between captures
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
    end else begin
      if (w_cap1) r_d1 <= r_high_cnt;
      if (w_cap23) begin
        r_d2 <= r_low_cnt;
        r_d3 <= r_per_cnt;
      end
    end
  end

  assign o_d1   = r_d1;
  assign o_d2   = r_d2;
  assign o_d3   = r_d3;
  assign o_cap3 = w_cap23;

endmodule

// File: rtl/edge_counter_quad.sv
// Four-channel high/low/period counter with a shared arm trigger and a
// combined trigger output. Define EDGE_COUNTER_SYNC_EN to synchronize sig_in.
module edge_counter_quad
  import edge_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic [3:0]       sig_in,
  input  logic             trig_in,
  input  logic [3:0]       enable,
  input  logic [3:0]       trig_enable,
  input  logic [3:0]       cfg_in_inv,
  input  logic [3:0]       cfg_trig_out,
  output logic             trig_out,
  output logic [CNT_W-1:0] d1_count_0,
  output logic [CNT_W-1:0] d1_count_1,
  output logic [CNT_W-1:0] d1_count_2,
  output logic [CNT_W-1:0] d1_count_3,
  output logic [CNT_W-1:0] d2_count_0,
  output logic [CNT_W-1:0] d2_count_1,
  output logic [CNT_W-1:0] d2_count_2,
  output logic [CNT_W-1:0] d2_count_3,
  output logic [CNT_W-1:0] d3_count_0,
  output logic [CNT_W-1:0] d3_count_1,
  output logic [CNT_W-1:0] d3_count_2,
  output logic [CNT_W-1:0] d3_count_3
);

  logic [CNT_W-1:0] w_d1 [N_CH];
  logic [CNT_W-1:0] w_d2 [N_CH];
  logic [CNT_W-1:0] w_d3 [N_CH];
  logic [N_CH-1:0]  w_cap3;
  logic             r_trig_out;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_counter_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n_sync    (rst_n_sync),
      .i_sig         (sig_in[g]),
      .i_trig        (trig_in),
      .i_enable      (enable[g]),
      .i_trig_enable (trig_enable[g]),
      .i_inv         (cfg_in_inv[g]),
      .o_d1          (w_d1[g]),
      .o_d2          (w_d2[g]),
      .o_d3          (w_d3[g]),
      .o_cap3        (w_cap3[g])
    );
  end

  // Registered OR of selected period captures; simultaneous captures merge
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) r_trig_out <= 1'b0;
    else             r_trig_out <= |(w_cap3 & cfg_trig_out);
  end

  assign trig_out   = r_trig_out;
  assign d1_count_0 = w_d1[0];
  assign d1_count_1 = w_d1[1];
  assign d1_count_2 = w_d1[2];
  assign d1_count_3 = w_d1[3];
  assign d2_count_0 = w_d2[0];
  assign d2_count_1 = w_d2[1];
  assign d2_count_2 = w_d2[2];
  assign d2_count_3 = w_d2[3];
  assign d3_count_0 = w_d3[0];
  assign d3_count_1 = w_d3[1];
  assign d3_count_2 = w_d3[2];
  assign d3_count_3 = w_d3[3];

endmodule

// File: tb/tb_edge_counter_quad.sv
// Self-checking bench for edge_counter_quad (8-bit counters, default build).
module tb_edge_counter_quad;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n_sync = 1'b0;
  logic [3:0]   sig_in = '0;
  logic         trig_in = 1'b0;
  logic [3:0]   enable = '0;
  logic [3:0]   trig_enable = '0;
  logic [3:0]   cfg_in_inv = '0;
  logic [3:0]   cfg_trig_out = '0;
  logic         trig_out;
  logic [W-1:0] d1 [4];
  logic [W-1:0] d2 [4];
  logic [W-1:0] d3 [4];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   trig_pulses = 0;
  int   trig_cycles = 0;
  logic trig_prev = 1'b0;

  edge_counter_quad #(
    .CNT_W (W)
  ) dut (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .sig_in       (sig_in),
    .trig_in      (trig_in),
    .enable       (enable),
    .trig_enable  (trig_enable),
    .cfg_in_inv   (cfg_in_inv),
    .cfg_trig_out (cfg_trig_out),
    .trig_out     (trig_out),
    .d1_count_0   (d1[0]),
    .d1_count_1   (d1[1]),
    .d1_count_2   (d1[2]),
    .d1_count_3   (d1[3]),
    .d2_count_0   (d2[0]),
    .d2_count_1   (d2[1]),
    .d2_count_2   (d2[2]),
    .d2_count_3   (d2[3]),
    .d3_count_0   (d3[0]),
    .d3_count_1   (d3[1]),
    .d3_count_2   (d3[2]),
    .d3_count_3   (d3[3])
  );

  always #5 clk = ~clk;

  // Count trig_out pulses and high cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (trig_out === 1'b1) begin
      trig_cycles++;
      if (trig_prev !== 1'b1) trig_pulses++;
    end
    trig_prev = trig_out;
  end

  function automatic exp_t mk_exp(input int hi, input int lo, input bit inv);
    exp_t e;
    int   a, b, s;
    a = inv ? lo : hi;
    b = inv ? hi : lo;
    s = hi + lo;
    e.d1 = (a > 255) ? 8'hFF : a[W-1:0];
    e.d2 = (b > 255) ? 8'hFF : b[W-1:0];
    e.d3 = (s > 255) ? 8'hFF : s[W-1:0];
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n periods of hi/lo cycles on one channel, then a final rise held 3 cycles
  task automatic run_wave(input int ch, input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      sig_in[ch] = 1'b1;
      cyc(hi);
      sig_in[ch] = 1'b0;
      cyc(lo);
    end
    sig_in[ch] = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset;
    rst_n_sync = 1'b0;
    cyc(3);
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d1[c] !== 8'd0 || d2[c] !== 8'd0 || d3[c] !== 8'd0) begin
        n_err++;
        $display("FAIL reset_ch%0d got %0d/%0d/%0d exp 0/0/0", c, d1[c], d2[c], d3[c]);
      end
    end
    n_vec++;
    if (trig_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_trig got %b exp 0", trig_out);
    end
    rst_n_sync = 1'b1;
    cyc(2);
  endtask

  task automatic test_continuous;
    exp_t e;
    trig_pulses = 0;
    enable[0] = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(7, 3, 1'b0));
    run_wave(0, 7, 3, 2);
    e = sb.pop_front();
    n_vec++;
    if (d1[0] !== e.d1 || d2[0] !== e.d2 || d3[0] !== e.d3) begin
      n_err++;
      $display("FAIL cont_7_3 got %0d/%0d/%0d exp %0d/%0d/%0d", d1[0], d2[0], d3[0], e.d1, e.d2, e.d3);
    end
    sb.push_back(mk_exp(6, 4, 1'b0));
    run_wave(0, 6, 4, 2);
    e = sb.pop_front();
    n_vec++;
    if (d1[0] !== e.d1 || d2[0] !== e.d2 || d3[0] !== e.d3) begin
      n_err++;
      $display("FAIL cont_refresh got %0d/%0d/%0d exp %0d/%0d/%0d", d1[0], d2[0], d3[0], e.d1, e.d2, e.d3);
    end
    n_vec++;
    if (trig_pulses !== 0) begin
      n_err++;
      $display("FAIL cont_no_trig got %0d pulses exp 0", trig_pulses);
    end
    sig_in[0] = 1'b0;
    enable[0] = 1'b0;
    cyc(4);
  endtask

  task automatic test_inversion;
    exp_t e;
    cfg_in_inv[0] = 1'b1;
    cyc(3);
    enable[0] = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(7, 3, 1'b1));
    run_wave(0, 7, 3, 3);
    e = sb.pop_front();
    n_vec++;
    if (d1[0] !== e.d1 || d2[0] !== e.d2 || d3[0] !== e.d3) begin
      n_err++;
      $display("FAIL inv_7_3 got %0d/%0d/%0d exp %0d/%0d/%0d", d1[0], d2[0], d3[0], e.d1, e.d2, e.d3);
    end
    enable[0] = 1'b0;
    cfg_in_inv[0] = 1'b0;
    sig_in[0] = 1'b0;
    cyc(4);
  endtask

  task automatic test_trigger;
    exp_t e;
    trig_pulses = 0;
    trig_cycles = 0;
    trig_enable[1] = 1'b1;
    cfg_trig_out[1] = 1'b1;
    enable[1] = 1'b1;
    cyc(3);
    trig_in = 1'b1;
    cyc(1);
    trig_in = 1'b0;
    cyc(1);
    sb.push_back(mk_exp(4, 4, 1'b0));
    run_wave(1, 4, 4, 2);
    cyc(2);
    e = sb.pop_front();
    n_vec++;
    if (d1[1] !== e.d1 || d2[1] !== e.d2 || d3[1] !== e.d3) begin
      n_err++;
      $display("FAIL trig_shot got %0d/%0d/%0d exp %0d/%0d/%0d", d1[1], d2[1], d3[1], e.d1, e.d2, e.d3);
    end
    n_vec++;
    if (trig_pulses !== 1 || trig_cycles !== 1) begin
      n_err++;
      $display("FAIL trig_out_once got %0d pulses/%0d cycles exp 1/1", trig_pulses, trig_cycles);
    end
    // without a new trig_in the channel must not capture again
    sb.push_back(mk_exp(4, 4, 1'b0));
    run_wave(1, 6, 2, 3);
    e = sb.pop_front();
    n_vec++;
    if (d1[1] !== e.d1 || d2[1] !== e.d2 || d3[1] !== e.d3) begin
      n_err++;
      $display("FAIL trig_hold got %0d/%0d/%0d exp %0d/%0d/%0d", d1[1], d2[1], d3[1], e.d1, e.d2, e.d3);
    end
    n_vec++;
    if (trig_pulses !== 1) begin
      n_err++;
      $display("FAIL trig_no_extra got %0d pulses exp 1", trig_pulses);
    end
    trig_in = 1'b1;
    cyc(1);
    trig_in = 1'b0;
    sb.push_back(mk_exp(6, 2, 1'b0));
    run_wave(1, 6, 2, 2);
    cyc(2);
    e = sb.pop_front();
    n_vec++;
    if (d1[1] !== e.d1 || d2[1] !== e.d2 || d3[1] !== e.d3) begin
      n_err++;
      $display("FAIL trig_rearm got %0d/%0d/%0d exp %0d/%0d/%0d", d1[1], d2[1], d3[1], e.d1, e.d2, e.d3);
    end
    n_vec++;
    if (trig_pulses !== 2 || trig_cycles !== 2) begin
      n_err++;
      $display("FAIL trig_out_twice got %0d pulses/%0d cycles exp 2/2", trig_pulses, trig_cycles);
    end
    enable[1] = 1'b0;
    trig_enable[1] = 1'b0;
    cfg_trig_out[1] = 1'b0;
    sig_in[1] = 1'b0;
    cyc(4);
  endtask

  task automatic test_saturation;
    exp_t e;
    enable[2] = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(300, 5, 1'b0));
    run_wave(2, 300, 5, 2);
    e = sb.pop_front();
    n_vec++;
    if (d1[2] !== e.d1 || d2[2] !== e.d2 || d3[2] !== e.d3) begin
      n_err++;
      $display("FAIL sat_300 got %0d/%0d/%0d exp %0d/%0d/%0d", d1[2], d2[2], d3[2], e.d1, e.d2, e.d3);
    end
    enable[2] = 1'b0;
    sig_in[2] = 1'b0;
    cyc(4);
  endtask

  task automatic test_enable_drop;
    exp_t e;
    enable[3] = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(8, 2, 1'b0));
    run_wave(3, 8, 2, 2);
    e = sb.pop_front();
    n_vec++;
    if (d1[3] !== e.d1 || d2[3] !== e.d2 || d3[3] !== e.d3) begin
      n_err++;
      $display("FAIL drop_pre got %0d/%0d/%0d exp %0d/%0d/%0d", d1[3], d2[3], d3[3], e.d1, e.d2, e.d3);
    end
    cyc(2);
    enable[3] = 1'b0;
    sb.push_back(mk_exp(8, 2, 1'b0));
    cyc(5);
    sig_in[3] = 1'b0;
    cyc(4);
    e = sb.pop_front();
    n_vec++;
    if (d1[3] !== e.d1 || d2[3] !== e.d2 || d3[3] !== e.d3) begin
      n_err++;
      $display("FAIL drop_hold got %0d/%0d/%0d exp %0d/%0d/%0d", d1[3], d2[3], d3[3], e.d1, e.d2, e.d3);
    end
    enable[3] = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(5, 5, 1'b0));
    run_wave(3, 5, 5, 2);
    e = sb.pop_front();
    n_vec++;
    if (d1[3] !== e.d1 || d2[3] !== e.d2 || d3[3] !== e.d3) begin
      n_err++;
      $display("FAIL drop_reenable got %0d/%0d/%0d exp %0d/%0d/%0d", d1[3], d2[3], d3[3], e.d1, e.d2, e.d3);
    end
    enable[3] = 1'b0;
    sig_in[3] = 1'b0;
    cyc(4);
  endtask

  task automatic test_back_to_back_reset;
    exp_t e;
    trig_pulses = 0;
    trig_cycles = 0;
    cfg_trig_out = 4'hF;
    enable = 4'hF;
    cyc(2);
    sb.push_back(mk_exp(6, 3, 1'b0));
    for (int p = 0; p < 3; p++) begin
      sig_in = 4'hF;
      cyc(6);
      sig_in = 4'h0;
      cyc(p < 2 ? 3 : 1);
    end
    e = sb.pop_front();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d1[c] !== e.d1 || d2[c] !== e.d2 || d3[c] !== e.d3) begin
        n_err++;
        $display("FAIL quad_ch%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, d1[c], d2[c], d3[c], e.d1, e.d2, e.d3);
      end
    end
    n_vec++;
    if (trig_pulses !== 2 || trig_cycles !== 2) begin
      n_err++;
      $display("FAIL quad_trig_merge got %0d pulses/%0d cycles exp 2/2", trig_pulses, trig_cycles);
    end
    // asynchronous reset in the middle of the low phase
    rst_n_sync = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d1[c] !== 8'd0 || d2[c] !== 8'd0 || d3[c] !== 8'd0) begin
        n_err++;
        $display("FAIL midlow_rst_ch%0d got %0d/%0d/%0d exp 0/0/0", c, d1[c], d2[c], d3[c]);
      end
    end
    n_vec++;
    if (trig_out !== 1'b0) begin
      n_err++;
      $display("FAIL midlow_rst_trig got %b exp 0", trig_out);
    end
    cyc(2);
    rst_n_sync = 1'b1;
    cyc(2);
    sb.push_back(mk_exp(4, 3, 1'b0));
    sig_in = 4'hF;
    cyc(4);
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d1[c] !== 8'd0 || d2[c] !== 8'd0 || d3[c] !== 8'd0) begin
        n_err++;
        $display("FAIL post_rst_idle_ch%0d got %0d/%0d/%0d exp 0/0/0", c, d1[c], d2[c], d3[c]);
      end
    end
    sig_in = 4'h0;
    cyc(3);
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d2[c] !== 8'd0 || d3[c] !== 8'd0) begin
        n_err++;
        $display("FAIL post_rst_nod3_ch%0d got %0d/%0d exp 0/0", c, d2[c], d3[c]);
      end
    end
    sig_in = 4'hF;
    cyc(3);
    e = sb.pop_front();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (d1[c] !== e.d1 || d2[c] !== e.d2 || d3[c] !== e.d3) begin
        n_err++;
        $display("FAIL post_rst_ch%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, d1[c], d2[c], d3[c], e.d1, e.d2, e.d3);
      end
    end
    enable = 4'h0;
    sig_in = 4'h0;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_inversion;
    test_trigger;
    test_saturation;
    test_enable_drop;
    test_back_to_back_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
